// File: rtl/tetris_pkg.sv
// Shared playfield types: tile shape, base position and the
// occupancy store's FSM state (exported for debug views).
package tetris;

    // [r][c] is the cell at (x+c, y+r) relative to the tile base.
    typedef struct packed {
        logic [3:0][3:0] shape_m;
    } shape_info_t;

    // Coordinates are two's complement so that bases left of or above
    // the field wrap to large unsigned values and read as walls.
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } point_t;

    typedef enum logic [1:0] {
        eIDLE  = 2'd0,
        eMerge = 2'd1,
        eScan  = 2'd2
    } mm_state_e;

endpackage

// File: rtl/matrix_window_read.sv
// 4x4 window extractor with wall padding; cells outside the field read 1.
// Ports: mem_i field, x_i/y_i window base, data_o[r][c] = cell (x+c, y+r).
module matrix_window_read #(
    parameter int width_p  = 16,
    parameter int height_p = 32,
    localparam int xw_lp   = $clog2(width_p) + 1,
    localparam int yw_lp   = $clog2(height_p) + 1
) (
    input  logic [height_p-1:0][width_p-1:0] mem_i,
    input  logic [xw_lp-1:0]                 x_i,
    input  logic [yw_lp-1:0]                 y_i,
    output logic [3:0][3:0]                  data_o
);

    // One extra bit so base + offset never wraps back into the field.
    logic [xw_lp:0] xx;
    logic [yw_lp:0] yy;

    always_comb begin
        data_o = '0;
        xx     = '0;
        yy     = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                xx = {1'b0, x_i} + (xw_lp+1)'(c);
                yy = {1'b0, y_i} + (yw_lp+1)'(r);
                if (xx >= (xw_lp+1)'(width_p) ||
                    yy >= (yw_lp+1)'(height_p))
                    data_o[r][c] = 1'b1;
                else
                    data_o[r][c] =
                        mem_i[yy[yw_lp-2:0]][xx[xw_lp-2:0]];
            end
        end
    end

endmodule

// File: rtl/matrix_memory.sv
// Playfield occupancy store: 4x4 window read, tile merge, line-clear scan.
// Ports: window (mm_addr_*/mm_data_o), merge (v_i/shape_i/pos_i), clear_i, done_o, lines_*, display row.
module matrix_memory
    import tetris::*;
#(
    parameter int width_p  = 16,
    parameter int height_p = 32,
    localparam int xw_lp   = $clog2(width_p) + 1,
    localparam int yw_lp   = $clog2(height_p) + 1,
    localparam int rw_lp   = $clog2(height_p)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [xw_lp-1:0]    mm_addr_r_x_i,
    input  logic [yw_lp-1:0]    mm_addr_r_y_i,
    output logic [3:0][3:0]     mm_data_o,
    input  logic                v_i,
    input  shape_info_t         shape_i,
    input  point_t              pos_i,
    input  logic                clear_i,
    output logic                done_o,
    output logic                lines_v_o,
    output logic [2:0]          lines_o,
    input  logic [rw_lp-1:0]    disp_row_i,
    output logic [width_p-1:0]  disp_row_o
);

    typedef logic [height_p-1:0][width_p-1:0] field_t;

    mm_state_e        state_r, state_n;
    field_t           mem_r, mem_n;
    logic [rw_lp-1:0] ptr_r, ptr_n;
    logic [2:0]       cnt_r, cnt_n;
    shape_info_t      shape_r;
    logic [xw_lp-1:0] x_r;
    logic [yw_lp-1:0] y_r;
    logic [3:0][3:0]  oob;
    logic [xw_lp:0]   mx;
    logic [yw_lp:0]   my;

    logic unused_pos;
    assign unused_pos = ^{pos_i.x[7:xw_lp], pos_i.y[7:yw_lp]};

    matrix_window_read #(
        .width_p (width_p),
        .height_p(height_p)
    ) u_win (
        .mem_i (mem_r),
        .x_i   (mm_addr_r_x_i),
        .y_i   (mm_addr_r_y_i),
        .data_o(mm_data_o)
    );

    // Against an empty field the extractor yields exactly the wall mask,
    // i.e. which tile cells land outside the field and must be dropped.
    matrix_window_read #(
        .width_p (width_p),
        .height_p(height_p)
    ) u_mask (
        .mem_i ('0),
        .x_i   (x_r),
        .y_i   (y_r),
        .data_o(oob)
    );

    assign done_o     = (state_r == eIDLE);
    assign disp_row_o = mem_r[disp_row_i];

    always_comb begin
        state_n   = state_r;
        mem_n     = mem_r;
        ptr_n     = ptr_r;
        cnt_n     = cnt_r;
        lines_v_o = 1'b0;
        lines_o   = '0;
        mx        = '0;
        my        = '0;
        unique case (state_r)
            eIDLE: begin
                if (clear_i)
                    mem_n = '0;
                else if (v_i)
                    state_n = eMerge;
            end
            eMerge: begin
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        mx = {1'b0, x_r} + (xw_lp+1)'(c);
                        my = {1'b0, y_r} + (yw_lp+1)'(r);
                        if (shape_r.shape_m[r][c] && !oob[r][c])
                            mem_n[my[rw_lp-1:0]][mx[xw_lp-2:0]] = 1'b1;
                    end
                end
                ptr_n   = '1;
                cnt_n   = '0;
                state_n = eScan;
            end
            eScan: begin
                if (&mem_r[ptr_r]) begin
                    // Drop everything above ptr by one row; ptr stays so
                    // the row shifted in is checked next cycle.
                    for (int i = 0; i < height_p; i++) begin
                        if (i == 0)
                            mem_n[i] = '0;
                        else if (i <= int'(ptr_r))
                            mem_n[i] = mem_r[i-1];
                    end
                    if (cnt_r != 3'd7)
                        cnt_n = cnt_r + 3'd1;
                end else if (ptr_r == '0) begin
                    lines_v_o = 1'b1;
                    lines_o   = cnt_r;
                    state_n   = eIDLE;
                end else begin
                    ptr_n = ptr_r - 1'b1;
                end
            end
            default: state_n = eIDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eIDLE;
            mem_r   <= '0;
            ptr_r   <= '1;
            cnt_r   <= '0;
            shape_r <= '0;
            x_r     <= '0;
            y_r     <= '0;
        end else begin
            state_r <= state_n;
            mem_r   <= mem_n;
            ptr_r   <= ptr_n;
            cnt_r   <= cnt_n;
            if (state_r == eIDLE && !clear_i && v_i) begin
                shape_r <= shape_i;
                x_r     <= pos_i.x[xw_lp-1:0];
                y_r     <= pos_i.y[yw_lp-1:0];
            end
        end
    end

endmodule

// File: tb/tb_matrix_memory.sv
// Directed bench for matrix_memory: window reads, merge, line clear,
// edge clipping, ignored requests, clear and reset abort.
module tb_matrix_memory;
    import tetris::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [4:0]        ax = '0;
    logic [5:0]        ay = '0;
    logic [3:0][3:0]   data;
    logic              v = 1'b0;
    shape_info_t       shape = '0;
    point_t            pos = '0;
    logic              clr = 1'b0;
    logic              done;
    logic              lines_v;
    logic [2:0]        lines;
    logic [4:0]        drow = '0;
    logic [15:0]       dout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    matrix_memory #(.width_p(16), .height_p(32)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .mm_addr_r_x_i(ax),
        .mm_addr_r_y_i(ay),
        .mm_data_o    (data),
        .v_i          (v),
        .shape_i      (shape),
        .pos_i        (pos),
        .clear_i      (clr),
        .done_o       (done),
        .lines_v_o    (lines_v),
        .lines_o      (lines),
        .disp_row_i   (drow),
        .disp_row_o   (dout)
    );

    task automatic read_row(input int r, output logic [15:0] val);
        drow = r[4:0];
        #1;
        val = dout;
    endtask

    task automatic read_win(input int x, input int y, output logic [15:0] val);
        ax = x[4:0];
        ay = y[5:0];
        #1;
        val = data;
    endtask

    task automatic start_merge(input logic [15:0] shp, input int x, input int y);
        @(posedge clk); #1;
        shape.shape_m = shp;
        pos.x = x[7:0];
        pos.y = y[7:0];
        v = 1'b1;
        @(posedge clk); #1;
        v = 1'b0;
    endtask

    // Returns cycles from the eMerge cycle to the lines_v pulse.
    task automatic do_merge(input logic [15:0] shp, input int x, input int y,
                            output int cyc, output int nl);
        start_merge(shp, x, y);
        cyc = 0;
        nl = -1;
        while (cyc < 200 && nl < 0) begin
            @(posedge clk); #1;
            cyc++;
            if (lines_v) nl = int'(lines);
        end
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] r;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++; $display("FAIL reset_done got %b want 1", done);
        end
        n_cmp++;
        if (lines_v !== 1'b0 || lines !== 3'd0) begin
            n_bad++; $display("FAIL reset_lines got %b/%0d want 0/0", lines_v, lines);
        end
        read_row(31, r);
        n_cmp++;
        if (r !== 16'h0000) begin
            n_bad++; $display("FAIL reset_row31 got %h want 0000", r);
        end
    endtask

    task automatic test_window();
        logic [15:0] w;
        int xs[4] = '{0, 14, 0, 0};
        int ys[4] = '{0, 0, 31, 63};
        logic [15:0] ex[4] = '{16'h0000, 16'hCCCC, 16'hFFF0, 16'hFFFF};
        for (int i = 0; i < 4; i++) begin
            read_win(xs[i], ys[i], w);
            n_cmp++;
            if (w !== ex[i]) begin
                n_bad++;
                $display("FAIL window_%0d x=%0d y=%0d got %h want %h",
                         i, xs[i], ys[i], w, ex[i]);
            end
        end
    endtask

    task automatic test_merge_simple();
        int cyc, nl;
        logic [15:0] r, w;
        do_merge(16'h0033, 0, 30, cyc, nl);
        n_cmp++;
        if (cyc !== 32 || nl !== 0) begin
            n_bad++; $display("FAIL merge_o_timing got cyc=%0d lines=%0d want 32/0", cyc, nl);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL merge_o_done_early got %b want 0", done);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++; $display("FAIL merge_o_done got %b want 1", done);
        end
        for (int i = 30; i < 32; i++) begin
            read_row(i, r);
            n_cmp++;
            if (r !== 16'h0003) begin
                n_bad++; $display("FAIL merge_o_row%0d got %h want 0003", i, r);
            end
        end
        read_win(0, 30, w);
        n_cmp++;
        if (w !== 16'hFF33) begin
            n_bad++; $display("FAIL merge_o_window got %h want ff33", w);
        end
    endtask

    task automatic test_clear();
        logic [15:0] r;
        int nz = 0;
        do_clear();
        for (int i = 0; i < 32; i++) begin
            read_row(i, r);
            if (r !== 16'h0000) nz++;
        end
        n_cmp++;
        if (nz !== 0) begin
            n_bad++; $display("FAIL clear_rows got %0d nonzero rows want 0", nz);
        end
    endtask

    task automatic test_line_clear();
        int cyc, nl;
        int bad = 0;
        logic [15:0] r;
        int px[4] = '{2, 6, 10, 14};
        logic [15:0] ps[4] = '{16'h00FF, 16'h00FF, 16'h00FF, 16'h0033};
        for (int i = 0; i < 4; i++) begin
            do_merge(ps[i], px[i], 30, cyc, nl);
            if (nl !== 0) bad++;
        end
        do_merge(16'h0005, 4, 29, cyc, nl);
        if (nl !== 0) bad++;
        n_cmp++;
        if (bad !== 0) begin
            n_bad++; $display("FAIL prefill_lines got %0d bad merges want 0", bad);
        end
        @(posedge clk);
        read_row(30, r);
        n_cmp++;
        if (r !== 16'hFFFC) begin
            n_bad++; $display("FAIL prefill_row30 got %h want fffc", r);
        end
        read_row(29, r);
        n_cmp++;
        if (r !== 16'h0050) begin
            n_bad++; $display("FAIL prefill_row29 got %h want 0050", r);
        end
        do_merge(16'h0033, 0, 30, cyc, nl);
        n_cmp++;
        if (cyc !== 34 || nl !== 2) begin
            n_bad++; $display("FAIL clear2_timing got cyc=%0d lines=%0d want 34/2", cyc, nl);
        end
        @(posedge clk);
        read_row(31, r);
        n_cmp++;
        if (r !== 16'h0050) begin
            n_bad++; $display("FAIL clear2_row31 got %h want 0050", r);
        end
        read_row(30, r);
        n_cmp++;
        if (r !== 16'h0000) begin
            n_bad++; $display("FAIL clear2_row30 got %h want 0000", r);
        end
        read_row(29, r);
        n_cmp++;
        if (r !== 16'h0000) begin
            n_bad++; $display("FAIL clear2_row29 got %h want 0000", r);
        end
    endtask

    task automatic test_right_edge();
        int cyc, nl;
        logic [15:0] r;
        do_merge(16'h00FF, 15, 10, cyc, nl);
        @(posedge clk);
        read_row(10, r);
        n_cmp++;
        if (r !== 16'h8000) begin
            n_bad++; $display("FAIL edge_row10 got %h want 8000", r);
        end
        read_row(11, r);
        n_cmp++;
        if (r !== 16'h8000) begin
            n_bad++; $display("FAIL edge_row11 got %h want 8000", r);
        end
        read_row(12, r);
        n_cmp++;
        if (r !== 16'h0000) begin
            n_bad++; $display("FAIL edge_row12 got %h want 0000", r);
        end
    endtask

    task automatic test_ignore_in_scan();
        int cyc = 0;
        int nl = -1;
        logic [15:0] r;
        do_clear();
        start_merge(16'h0033, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        shape.shape_m = 16'hFFFF;
        pos.x = 8'd8;
        pos.y = 8'd8;
        v = 1'b1;
        clr = 1'b1;
        @(posedge clk); #1;
        v = 1'b0;
        clr = 1'b0;
        cyc = 6;
        while (cyc < 200 && nl < 0) begin
            if (lines_v) nl = int'(lines);
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        n_cmp++;
        if (cyc !== 32 || nl !== 0) begin
            n_bad++; $display("FAIL ignore_timing got cyc=%0d lines=%0d want 32/0", cyc, nl);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++; $display("FAIL ignore_done got %b want 1", done);
        end
        read_row(0, r);
        n_cmp++;
        if (r !== 16'h0003) begin
            n_bad++; $display("FAIL ignore_row0 got %h want 0003", r);
        end
        read_row(8, r);
        n_cmp++;
        if (r !== 16'h0000) begin
            n_bad++; $display("FAIL ignore_row8 got %h want 0000", r);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [15:0] r;
        start_merge(16'h0033, 0, 30);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL midscan_busy got %b want 0", done);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || lines_v !== 1'b0) begin
            n_bad++; $display("FAIL midscan_reset got done=%b lv=%b want 1/0", done, lines_v);
        end
        read_row(30, r);
        n_cmp++;
        if (r !== 16'h0000) begin
            n_bad++; $display("FAIL midscan_row30 got %h want 0000", r);
        end
        read_row(0, r);
        n_cmp++;
        if (r !== 16'h0000) begin
            n_bad++; $display("FAIL midscan_row0 got %h want 0000", r);
        end
    endtask

    initial begin
        test_reset();
        test_window();
        test_merge_simple();
        test_clear();
        test_line_clear();
        test_right_edge();
        test_ignore_in_scan();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
